// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte frame and writes
// assembled 32-bit words into the program RAM, then reports Done or Error.
`timescale 1ns/1ps
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [15:0] MAX_N = 16'(MEMORY_DEPTH);
  localparam int          PAD   = DATA_WIDTH - 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  acc;
  logic [15:0]           len_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    ByteReady = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    unique case (state_q)
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
      end
      S_DONE:  Done  = 1'b1;
      S_ERROR: Error = 1'b1;
      default: ;
    endcase
  end

  assign acc          = ByteValid & ByteReady;
  assign len_n        = {len_q[15:8], ByteIn};
  assign WriteEnable  = we_q;
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE,
      S_DONE,
      S_ERROR: begin
        if (Start) begin
          state_d = S_LEN_HI;
          len_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
          shift_d = '0;
          csum_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d[15:8] = ByteIn;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = len_n;
          if (len_n > MAX_N) begin
            state_d = S_ERROR;
          end else if (len_n == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          csum_d  = csum_q ^ ByteIn;
          bcnt_d  = bcnt_q + 2'd1;
          shift_d = {shift_q[15:0], ByteIn};
          // Fourth byte: register the word so the strobe lands next cycle.
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {shift_q, ByteIn};
            waddr_d = {{PAD{1'b0}}, idx_q, 2'b00};
            idx_d   = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (acc) begin
          state_d = (ByteIn == csum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of frames plus reset/Start corner sequences,
// with a write scoreboard fed when frames are driven.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Error;

  program_loader #(
    .MEMORY_DEPTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  cks;
    int          gap;
    bit          done;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t        tbl [8];
  wr_t         exp_q [$];
  logic [31:0] wq [$];
  int          tests = 0;
  int          fails = 0;
  int          n_we  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (WriteEnable === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 WriteAddress, WriteData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", WriteAddress, e.a);
        chk("wr_data", WriteData, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    ByteIn    = b;
    ByteValid = 1'b1;
    k = 0;
    while (!ByteReady && k < 20) begin
      tick();
      k++;
    end
    if (!ByteReady) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    tick();
    ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic gap_wait(input int gap);
    repeat (gap) tick();
  endtask

  // Frame from wq; pause_at>=0 pulses Start after that many data bytes.
  task automatic send_frame(input logic [15:0] len, input logic [7:0] cks,
                            input int gap, input int pause_at);
    wr_t e;
    int  nb;
    n_we = 0;
    pulse_start();
    send_byte(len[15:8]);
    gap_wait(gap);
    send_byte(len[7:0]);
    if (len <= 16'd32) begin
      for (int i = 0; i < wq.size(); i++) begin
        e.a = 32'(i * 4);
        e.d = wq[i];
        exp_q.push_back(e);
      end
      nb = 0;
      for (int i = 0; i < wq.size(); i++) begin
        for (int j = 3; j >= 0; j--) begin
          gap_wait(gap);
          send_byte(wq[i][j*8 +: 8]);
          nb++;
          if (nb == pause_at) begin
            pulse_start();
          end
        end
      end
      gap_wait(gap);
      send_byte(cks);
    end
  endtask

  task automatic check_end(input bit done, input bit err, input int nwe);
    chk("done", 32'(Done), 32'(done));
    chk("error", 32'(Error), 32'(err));
    chk("busy", 32'(Busy), 32'd0);
    chk("byte_ready", 32'(ByteReady), 32'd0);
    repeat (2) tick();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(n_we), 32'(nwe));
    exp_q.delete();
  endtask

  task automatic load_case1(input int gap, input int pause_at);
    wq.delete();
    wq.push_back(32'h20080005);
    wq.push_back(32'h01095020);
    send_frame(16'd2, 8'h55, gap, pause_at);
  endtask

  initial begin
    logic [7:0] cs;
    int         nw;
    tbl[0] = '{16'd2,   32'h20080005, 32'h01095020, 8'h55, 0, 1'b1, 1'b0};
    tbl[1] = '{16'd0,   32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0};
    tbl[2] = '{16'd0,   32'h0,        32'h0,        8'h01, 0, 1'b0, 1'b1};
    tbl[3] = '{16'd33,  32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1};
    tbl[4] = '{16'd2,   32'h20080005, 32'h01095020, 8'h55, 3, 1'b1, 1'b0};
    tbl[5] = '{16'd1,   32'hDEADBEEF, 32'h0,        8'h22, 1, 1'b1, 1'b0};
    tbl[6] = '{16'd2,   32'h20080005, 32'h01095020, 8'h54, 0, 1'b0, 1'b1};
    tbl[7] = '{16'h100, 32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1};

    reset     = 1'b1;
    Start     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_ready", 32'(ByteReady), 32'd0);
    chk("rst_we", 32'(WriteEnable), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_addr", WriteAddress, 32'd0);
    chk("rst_data", WriteData, 32'd0);

    for (int v = 0; v < 8; v++) begin
      wq.delete();
      nw = (tbl[v].len <= 16'd2) ? int'(tbl[v].len) : 0;
      if (nw > 0) wq.push_back(tbl[v].w0);
      if (nw > 1) wq.push_back(tbl[v].w1);
      send_frame(tbl[v].len, tbl[v].cks, tbl[v].gap, -1);
      check_end(tbl[v].done, tbl[v].err, tbl[v].err && nw != 2 ? 0 : nw);
    end

    // Full-depth image with a bench-computed checksum.
    wq.delete();
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      wq.push_back(32'(i) * 32'h01030507 ^ 32'hA5C3_0F1E);
    end
    for (int i = 0; i < 32; i++) begin
      cs = cs ^ wq[i][31:24] ^ wq[i][23:16] ^ wq[i][15:8] ^ wq[i][7:0];
    end
    send_frame(16'd32, cs, 0, -1);
    check_end(1'b1, 1'b0, 32);

    // Start during DATA is ignored.
    load_case1(0, 5);
    check_end(1'b1, 1'b0, 2);

    // Start in DONE clears flags and begins a new load.
    pulse_start();
    chk("restart_done", 32'(Done), 32'd0);
    chk("restart_busy", 32'(Busy), 32'd1);
    chk("restart_ready", 32'(ByteReady), 32'd1);

    // Reset mid-load after 6 data bytes: only word 0 written.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_we = 0;
    exp_q.push_back('{32'h0, 32'h20080005});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h09);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ready", 32'(ByteReady), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_error", 32'(Error), 32'd0);
    chk("mid_rst_addr", WriteAddress, 32'd0);
    chk("mid_rst_data", WriteData, 32'd0);
    repeat (3) tick();
    chk("mid_rst_we_count", 32'(n_we), 32'd1);
    chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    load_case1(0, -1);
    check_end(1'b1, 1'b0, 2);

    // Reset wins over Start in the same cycle.
    reset = 1'b1;
    Start = 1'b1;
    tick();
    reset = 1'b0;
    Start = 1'b0;
    chk("rst_wins_busy", 32'(Busy), 32'd0);
    chk("rst_wins_ready", 32'(ByteReady), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
